des_key_sched: RTL and testbench

- Sequential DES/3DES key-schedule engine.
- Accepts a 64-bit key (or three keys for 3DES) through a valid/ready handshake and applies Permuted Choice 1.
- Iterates the 16-round C/D rotation schedule and streams one 48-bit PC2 subkey per handshake to the round datapath.
- Supports encrypt and decrypt ordering and 1-key or 3-key (EDE) operation.

---
 rtl/des_pkg.sv | 54 +++++
 rtl/des_pc2.sv | 9 +
 rtl/des_key_sched.sv | 157 +++++++++++++++
 tb/tb_des_key_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, widths, FSM states and permutation/rotation helpers.
package des_pkg;
  localparam int W28 = 28;
  localparam int W48 = 48;
  localparam int W56 = 56;
  localparam int W64 = 64;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  // Entries are 1-based DES bit numbers of the source vector.
  localparam int PC1_T [W56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [W48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [1:W56] pc1(input logic [1:W64] k);
    logic [1:W56] p;
    for (int i = 0; i < W56; i++) p[i+1] = k[PC1_T[i]];
    return p;
  endfunction

  function automatic logic [1:W48] pc2(input logic [1:W56] cd);
    logic [1:W48] p;
    for (int i = 0; i < W48; i++) p[i+1] = cd[PC2_T[i]];
    return p;
  endfunction

  function automatic logic [1:W28] rotl28(input logic [1:W28] x, input int n);
    return n == 1 ? {x[2:28], x[1]} : {x[3:28], x[1:2]};
  endfunction

  function automatic logic [1:W28] rotr28(input logic [1:W28] x, input int n);
    return n == 1 ? {x[28], x[1:27]} : {x[27:28], x[1:26]};
  endfunction
endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational PC2 permutation of the 56-bit C||D state into a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [1:W56] cd,
  output logic [1:W48] sk
);
  assign sk = pc2(cd);
endmodule

// File: rtl/des_key_sched.sv
// des_key_sched: sequential DES/3DES (EDE) key schedule streaming PC2 subkeys over valid/ready.
// Optional DES_KEY_PARITY_CHECK_EN adds parity_err and rejects keys with any even-parity byte.
module des_key_sched
  import des_pkg::*;
#(
  parameter int NUM_KEYS = 1,
  parameter bit OUT_REG  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  output logic                   key_ready,
  input  logic [1:64*NUM_KEYS]   key_in,
  input  logic                   decrypt,
  output logic                   sk_valid,
  input  logic                   sk_ready,
  output logic [1:W48]           sk_out,
  output logic [3:0]             sk_round,
  output logic [1:0]             sk_key_idx,
  output logic                   sk_dec,
  output logic                   sk_last
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic                   parity_err
`endif
);
  localparam int KW = W64 * NUM_KEYS;
  localparam logic [1:0] LAST_PASS = 2'(NUM_KEYS - 1);

  state_t state_q, state_d;
  logic [1:KW] keys_q, keys_d;
  logic dec_q, dec_d, pass_dec_q, pass_dec_d;
  logic sk_valid_q, sk_valid_d, key_ready_q, key_ready_d;
  logic [1:0] pass_q, pass_d;
  logic [3:0] round_q, round_d;
  logic [1:W28] c_q, c_d, d_q, d_d;
  logic [1:W64] pass_key;
  logic [1:W56] pc1_key, pc2_in;
  logic [1:W48] pc2_out, sk_out_q;
  logic key_hs, sk_hs, key_ok;

  if (NUM_KEYS != 1 && NUM_KEYS != 3) begin : g_bad
    $error("des_key_sched: NUM_KEYS must be 1 or 3");
  end

  // Encrypt walks keys K1..K3, decrypt walks K3..K1.
  if (NUM_KEYS == 3) begin : g_k3
    logic [1:0] key_idx;
    assign key_idx = dec_q ? LAST_PASS - pass_q : pass_q;
    assign pass_key = key_idx == 2'd0 ? keys_q[1:64] :
                      key_idx == 2'd1 ? keys_q[65:128] : keys_q[129:192];
  end else begin : g_k1
    assign pass_key = keys_q[1:64];
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic par_err_q;
  always_comb begin
    key_ok = 1'b1;
    for (int b = 0; b < KW / 8; b++) key_ok &= ^key_in[8*b+1 +: 8];
  end
  always_ff @(posedge clk) par_err_q <= rst ? 1'b0 : key_hs && !key_ok;
  assign parity_err = par_err_q;
`else
  assign key_ok = 1'b1;
`endif

  assign key_hs  = key_valid && key_ready_q;
  assign sk_hs   = sk_valid_q && sk_ready;
  assign pc1_key = pc1(pass_key);

  always_comb begin
    state_d     = state_q;
    keys_d      = keys_q;
    dec_d       = dec_q;
    pass_dec_d  = pass_dec_q;
    sk_valid_d  = sk_valid_q;
    key_ready_d = key_ready_q;
    pass_d      = pass_q;
    round_d     = round_q;
    c_d         = c_q;
    d_d         = d_q;
    if (state_q == S_IDLE && key_hs && key_ok) begin
      state_d     = S_LOAD;
      keys_d      = key_in;
      dec_d       = decrypt;
      pass_d      = 2'd0;
      round_d     = 4'd0;
      key_ready_d = 1'b0;
    end
    // Encrypt pre-rotates for round 0; decrypt's round 0 uses PC1 as-is.
    if (state_q == S_LOAD) begin
      pass_dec_d = dec_q ^ (pass_q == 2'd1);
      c_d        = pass_dec_d ? pc1_key[1:28]  : rotl28(pc1_key[1:28], SHIFT_T[0]);
      d_d        = pass_dec_d ? pc1_key[29:56] : rotl28(pc1_key[29:56], SHIFT_T[0]);
      round_d    = 4'd0;
      sk_valid_d = 1'b1;
      state_d    = S_RUN;
    end
    if (state_q == S_RUN && sk_hs) begin
      if (round_q == 4'd15) begin
        sk_valid_d  = 1'b0;
        state_d     = pass_q == LAST_PASS ? S_IDLE : S_LOAD;
        key_ready_d = pass_q == LAST_PASS;
        pass_d      = pass_q == LAST_PASS ? pass_q : pass_q + 2'd1;
      end else begin
        round_d = round_q + 4'd1;
        c_d = pass_dec_q ? rotr28(c_q, SHIFT_T[4'd15 - round_q]) : rotl28(c_q, SHIFT_T[round_q + 4'd1]);
        d_d = pass_dec_q ? rotr28(d_q, SHIFT_T[4'd15 - round_q]) : rotl28(d_q, SHIFT_T[round_q + 4'd1]);
      end
    end
  end

  // Registered output permutes the next C/D so both modes present the same cycle's subkey.
  assign pc2_in = OUT_REG ? {c_d, d_d} : {c_q, d_q};

  des_pc2 u_pc2 (
    .cd (pc2_in),
    .sk (pc2_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      keys_q      <= '0;
      dec_q       <= 1'b0;
      pass_dec_q  <= 1'b0;
      sk_valid_q  <= 1'b0;
      key_ready_q <= 1'b1;
      pass_q      <= 2'd0;
      round_q     <= 4'd0;
      c_q         <= '0;
      d_q         <= '0;
      sk_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      keys_q      <= keys_d;
      dec_q       <= dec_d;
      pass_dec_q  <= pass_dec_d;
      sk_valid_q  <= sk_valid_d;
      key_ready_q <= key_ready_d;
      pass_q      <= pass_d;
      round_q     <= round_d;
      c_q         <= c_d;
      d_q         <= d_d;
      sk_out_q    <= pc2_out;
    end
  end

  assign key_ready  = key_ready_q;
  assign sk_valid   = sk_valid_q;
  assign sk_out     = OUT_REG ? sk_out_q : pc2_out;
  assign sk_round   = round_q;
  assign sk_key_idx = pass_q;
  assign sk_dec     = pass_dec_q;
  assign sk_last    = sk_valid_q && pass_q == LAST_PASS && round_q == 4'd15;
endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched: directed checks of single-DES and 3DES key schedules against known subkeys.
module tb_des_key_sched;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KZ  = 64'h0101010101010101;
  localparam logic [63:0] KO  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [47:0] KT [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic k1_valid, k1_ready, k1_dec, s1_valid, s1_ready, s1_dec, s1_last;
  logic [1:64] k1_in;
  logic [1:48] s1_out;
  logic [3:0] s1_round;
  logic [1:0] s1_idx;
  logic k3_valid, k3_ready, k3_dec, s3_valid, s3_ready, s3_dec, s3_last;
  logic [1:192] k3_in;
  logic [1:48] s3_out;
  logic [3:0] s3_round;
  logic [1:0] s3_idx;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic p1_err, p3_err;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  des_key_sched #(.NUM_KEYS(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst), .key_valid(k1_valid), .key_ready(k1_ready), .key_in(k1_in),
    .decrypt(k1_dec), .sk_valid(s1_valid), .sk_ready(s1_ready), .sk_out(s1_out),
    .sk_round(s1_round), .sk_key_idx(s1_idx), .sk_dec(s1_dec), .sk_last(s1_last)
`ifdef DES_KEY_PARITY_CHECK_EN
    , .parity_err(p1_err)
`endif
  );

  des_key_sched #(.NUM_KEYS(3), .OUT_REG(0)) u3 (
    .clk(clk), .rst(rst), .key_valid(k3_valid), .key_ready(k3_ready), .key_in(k3_in),
    .decrypt(k3_dec), .sk_valid(s3_valid), .sk_ready(s3_ready), .sk_out(s3_out),
    .sk_round(s3_round), .sk_key_idx(s3_idx), .sk_dec(s3_dec), .sk_last(s3_last)
`ifdef DES_KEY_PARITY_CHECK_EN
    , .parity_err(p3_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] exp_sk(input logic [63:0] k, input logic pdec, input int r);
    int i;
    i = pdec ? 15 - r : r;
    return k == KZ ? 48'h0 : k == KO ? 48'hFFFFFFFFFFFF : KT[i];
  endfunction

  task automatic start1(input logic dec);
    @(negedge clk);
    chk("k1_ready_idle", k1_ready, 1);
    k1_valid = 1'b1; k1_in = KEY; k1_dec = dec;
    @(negedge clk);
    chk("k1_load_valid", s1_valid, 0);
    chk("k1_load_ready", k1_ready, 0);
    k1_in = ~KEY; k1_dec = ~dec;
    @(negedge clk);
    k1_valid = 1'b0;
  endtask

  task automatic run1(input logic dec, input logic bp);
    int r = 0, cyc = 0, first = -1, last = -1;
    while (r < 16 && cyc < 400) begin
      if (s1_valid) begin
        if (first < 0) first = cyc;
        chk("k1_round", s1_round, r);
        chk("k1_sk", s1_out, exp_sk(KEY, dec, r));
        chk("k1_last", s1_last, r == 15);
        chk("k1_dec", s1_dec, dec);
      end
      s1_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s1_valid && s1_ready) begin r++; last = cyc; end
      @(negedge clk); cyc++;
    end
    chk("k1_count", r, 16);
    if (!bp) begin
      chk("k1_first_lat", first, 0);
      chk("k1_burst", last - first, 15);
    end
    chk("k1_end_valid", s1_valid, 0);
    chk("k1_end_ready", k1_ready, 1);
  endtask

  task automatic run3(input logic dec, input logic distinct);
    int n = 0, cyc = 0, gaps = 0, p, r, kid;
    bit seen = 0;
    logic pdec;
    logic [63:0] k;
    @(negedge clk);
    chk("k3_ready_idle", k3_ready, 1);
    k3_valid = 1'b1; k3_dec = dec;
    k3_in = distinct ? {KEY, KZ, KO} : {KEY, KEY, KEY};
    @(negedge clk);
    k3_valid = 1'b0; k3_in = '0; k3_dec = ~dec;
    chk("k3_load_valid", s3_valid, 0);
    s3_ready = 1'b1;
    while (n < 48 && cyc < 400) begin
      if (s3_valid) begin
        seen = 1; p = n / 16; r = n % 16;
        pdec = dec ^ (p == 1);
        kid = dec ? 2 - p : p;
        k = !distinct ? KEY : kid == 0 ? KEY : kid == 1 ? KZ : KO;
        chk("k3_idx", s3_idx, p);
        chk("k3_dec", s3_dec, pdec);
        chk("k3_round", s3_round, r);
        chk("k3_sk", s3_out, exp_sk(k, pdec, r));
        chk("k3_last", s3_last, n == 47);
        n++;
      end else if (seen) gaps++;
      @(negedge clk); cyc++;
    end
    chk("k3_count", n, 48);
    chk("k3_gaps", gaps, 2);
    chk("k3_end_valid", s3_valid, 0);
    chk("k3_end_ready", k3_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    k1_valid = 1'b0; k1_in = '0; k1_dec = 1'b0; s1_ready = 1'b0;
    k3_valid = 1'b0; k3_in = '0; k3_dec = 1'b0; s3_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", k1_ready, 1);
    chk("rst_valid", s1_valid, 0);
    chk("rst_sk", s1_out, 0);
    chk("rst_round", s1_round, 0);
    chk("rst_idx", s1_idx, 0);
    chk("rst_dec", s1_dec, 0);
    chk("rst_last", s1_last, 0);
    chk("rst3_ready", k3_ready, 1);
    chk("rst3_valid", s3_valid, 0);
    chk("rst3_sk", s3_out, 0);
    rst = 1'b0;
`ifndef DES_KEY_PARITY_CHECK_EN
    start1(1'b0); run1(1'b0, 1'b0);
    start1(1'b1); run1(1'b1, 1'b0);
    start1(1'b0); run1(1'b0, 1'b1);
    start1(1'b1); run1(1'b1, 1'b1);
    run3(1'b0, 1'b0);
    run3(1'b1, 1'b1);
    run3(1'b0, 1'b1);
    start1(1'b0);
    s1_ready = 1'b1;
    cyc = 0;
    while (!(s1_valid && s1_round == 4'd7) && cyc < 100) begin @(negedge clk); cyc++; end
    chk("mid_round7", s1_round, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", s1_valid, 0);
    chk("mid_rst_ready", k1_ready, 1);
    chk("mid_rst_round", s1_round, 0);
    chk("mid_rst_sk", s1_out, 0);
    rst = 1'b0;
    start1(1'b0); run1(1'b0, 1'b0);
`else
    @(negedge clk);
    chk("par_ready", k1_ready, 1);
    k1_valid = 1'b1; k1_in = 64'h133457799BBCDFF0; k1_dec = 1'b0;
    @(negedge clk);
    k1_valid = 1'b0;
    chk("par_err_pulse", p1_err, 1);
    chk("par_err_ready", k1_ready, 1);
    chk("par_err_valid", s1_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("par_err_clear", p1_err, 0);
      chk("par_no_sk", s1_valid, 0);
    end
    k1_valid = 1'b1; k1_in = KZ;
    @(negedge clk);
    k1_valid = 1'b0;
    chk("par_ok_err", p1_err, 0);
    chk("par_ok_load", k1_ready, 0);
    @(negedge clk);
    chk("par_ok_valid", s1_valid, 1);
    chk("par_ok_sk", s1_out, 0);
    chk("par_ok_round", s1_round, 0);
    s1_ready = 1'b1;
    repeat (16) @(negedge clk);
    chk("par_ok_end_valid", s1_valid, 0);
    chk("par_ok_end_ready", k1_ready, 1);
    chk("par_ok_end_err", p1_err, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
